// File: rtl/sdf_fft_sequencer.sv
// Central sequencer for a pipelined radix-2 SDF FFT: one shared advance enable,
// per-stage butterfly selects and twiddle addresses, output framing and end-of-stream drain.
module sdf_fft_sequencer #(
    parameter int N_LOG2    = 5,
    parameter int STAGE_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic                           en,
    output logic [N_LOG2-1:0]              bf_sel,
    output logic [N_LOG2*(N_LOG2-1)-1:0]   tw_addr,
    output logic                           out_valid,
    output logic                           out_last,
    output logic                           busy
);

    localparam int L   = N_LOG2;
    localparam int N   = 1 << L;
    localparam int AW  = L - 1;
    localparam int LAT = N - 1 + L * STAGE_LAT;
    localparam int FW  = $clog2(LAT + 1);

    localparam logic [L-1:0]  CNT_LAST = L'(N - 1);
    localparam logic [FW-1:0] LAT_F    = FW'(LAT);
    localparam logic [FW-1:0] DRAIN_END = FW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t state, next_state;

    logic [L-1:0]      cnt;
    logic [L-1:0]      ocnt;
    logic [FW-1:0]     fill;
    logic [FW-1:0]     drain;
    logic              flush_pend;
    logic              take;
    logic              show;
    logic [L-1:0]      sel_raw;
    logic [L*AW-1:0]   tw_raw;

    // Offset of the sample stream seen by stage s: delay lines plus register latency of earlier stages.
    function automatic logic [L-1:0] stage_off(input int s);
        int acc;
        acc = 0;
        for (int k = 0; k < s; k++) begin
            acc = acc + (N >> (k + 1)) + STAGE_LAT;
        end
        return L'(acc % N);
    endfunction

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        en         = 1'b0;
        take       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                en       = in_valid;
                take     = in_valid;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                en       = in_valid;
                take     = in_valid;
                // A pending flush fires only once the current frame is complete.
                if ((flush_pend || flush) && (take ? (cnt == CNT_LAST) : (cnt == '0)))
                    next_state = FLUSH;
            end
            FLUSH: begin
                en = 1'b1;
                if (drain == DRAIN_END) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ocnt       <= '0;
            fill       <= '0;
            drain      <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= next_state;
            if (take)                cnt  <= cnt + 1'b1;
            if (en && fill != LAT_F) fill <= fill + 1'b1;
            if (out_valid)           ocnt <= ocnt + 1'b1;
            if (state == RUN && flush) flush_pend <= 1'b1;
            if (state == FLUSH)      drain <= drain + 1'b1;
            if (state == FLUSH && next_state == IDLE) begin
                cnt        <= '0;
                ocnt       <= '0;
                fill       <= '0;
                drain      <= '0;
                flush_pend <= 1'b0;
            end
        end
    end

    // Per-stage schedule; the last stage has a zero mask so its twiddle address is always 0.
    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam logic [L-1:0] OFF  = stage_off(s);
        localparam logic [L-1:0] MASK = L'((N >> (s + 1)) - 1);
        logic [L-1:0] c_idx;
        assign c_idx      = cnt - OFF;
        assign sel_raw[s] = c_idx[L-1-s];
        assign tw_raw[s*AW +: AW] = sel_raw[s] ? '0 : AW'((c_idx & MASK) << s);
    end

    assign show      = (state != IDLE) || in_valid;
    assign bf_sel    = show ? sel_raw : '0;
    assign tw_addr   = show ? tw_raw  : '0;
    assign out_valid = en && (fill == LAT_F);
    assign out_last  = out_valid && (ocnt == CNT_LAST);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sdf_fft_sequencer.sv
// Scoreboard bench for sdf_fft_sequencer: a beat-counting reference model predicts every
// cycle, and a negedge monitor compares the DUT against the queued predictions.
module tb_sdf_fft_sequencer;

    localparam int L   = 5;
    localparam int N   = 32;
    localparam int SL  = 1;
    localparam int LAT = N - 1 + L * SL;
    localparam int AW  = L - 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            en;
    logic [L-1:0]    bf_sel;
    logic [L*AW-1:0] tw_addr;
    logic            out_valid;
    logic            out_last;
    logic            busy;

    sdf_fft_sequencer #(.N_LOG2(L), .STAGE_LAT(SL)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .en       (en),
        .bf_sel   (bf_sel),
        .tw_addr  (tw_addr),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              chk;
        bit              chk_sched;
        bit              ir;
        bit              en;
        bit              busy;
        bit              ov;
        bit              ol;
        logic [L-1:0]    bf;
        logic [L*AW-1:0] tw;
    } exp_t;

    exp_t ctl_q[$];
    bit   out_q[$];

    int checks = 0;
    int errors = 0;
    int obs_out = 0;
    int obs_last = 0;

    // Reference model: mode 0 idle, 1 streaming, 2 draining; counts are plain totals.
    int m_mode  = 0;
    int m_beats = 0;
    int m_enb   = 0;
    int m_drain = 0;
    bit m_pend  = 0;

    function automatic int stageOffset(input int s);
        int acc = 0;
        for (int k = 0; k < s; k++) acc += (N >> (k + 1)) + SL;
        return acc % N;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit f);
        exp_t e;
        bit   take;
        int   cnt;
        bit   boundary;
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        flush    = f;

        e.ir   = (m_mode != 2);
        e.en   = (m_mode == 2) ? 1'b1 : v;
        e.busy = (m_mode != 0);
        take   = v && (m_mode != 2);
        cnt    = m_beats % N;
        e.ov   = e.en && (m_enb >= LAT);
        e.ol   = e.ov && (((m_enb - LAT) % N) == N - 1);
        e.chk  = !r;
        e.chk_sched = !r && (m_mode != 2);
        e.bf = '0;
        e.tw = '0;
        if (m_mode != 0 || v) begin
            for (int s = 0; s < L; s++) begin
                int c, d, sel, tw;
                c   = (cnt - stageOffset(s) + 2 * N) % N;
                d   = N >> (s + 1);
                sel = (c / d) % 2;
                tw  = sel ? 0 : (c % d) * (1 << s);
                e.bf[s] = sel[0];
                e.tw    = e.tw | ((L*AW)'(tw) << (s * AW));
            end
        end
        ctl_q.push_back(e);
        if (e.ov && !r) out_q.push_back(e.ol);

        if (r) begin
            m_mode = 0; m_beats = 0; m_enb = 0; m_drain = 0; m_pend = 0;
        end else if (m_mode == 0) begin
            if (take) begin
                m_mode = 1; m_beats = 1; m_enb = 1;
            end
        end else if (m_mode == 1) begin
            boundary = take ? (((m_beats + 1) % N) == 0) : ((m_beats % N) == 0);
            if (e.en) m_enb++;
            if (take) m_beats++;
            if ((m_pend || f) && boundary) begin
                m_mode = 2; m_drain = 0;
            end else if (f) begin
                m_pend = 1;
            end
        end else begin
            m_enb++;
            m_drain++;
            if (m_drain == LAT) begin
                m_mode = 0; m_beats = 0; m_enb = 0; m_drain = 0; m_pend = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   xl;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            if (e.chk) begin
                checkOutput("in_ready", 32'(in_ready), 32'(e.ir));
                checkOutput("en", 32'(en), 32'(e.en));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("out_valid", 32'(out_valid), 32'(e.ov));
                checkOutput("out_last", 32'(out_last), 32'(e.ol));
                if (e.chk_sched) begin
                    checkOutput("bf_sel", 32'(bf_sel), 32'(e.bf));
                    checkOutput("tw_addr", 32'(tw_addr), 32'(e.tw));
                end
            end
        end
        if (out_valid === 1'b1 && rst === 1'b0) begin
            obs_out++;
            if (out_last === 1'b1) obs_last++;
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL out_beat actual=unexpected expected=none at %0t", $time);
            end else begin
                xl = out_q.pop_front();
                checkOutput("out_beat_last", 32'(out_last), 32'(xl));
            end
        end
    end

    task automatic drainToIdle(input int budget);
        int n = 0;
        while (m_mode != 0 && n < budget) begin
            applyStimulus(0, 0, 0);
            n++;
        end
        checkOutput("drain_bound", 32'(m_mode), 32'd0);
    endtask

    initial begin
        int o0, l0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;

        $display("[TB] test 1: reset");
        repeat (3) applyStimulus(1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0);

        $display("[TB] test 2/3: one frame then flush");
        o0 = obs_out; l0 = obs_last;
        for (int i = 0; i < N; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        drainToIdle(100);
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("flush_out_count", 32'(obs_out - o0), 32'd32);
        checkOutput("flush_last_count", 32'(obs_last - l0), 32'd1);

        $display("[TB] test 4: frame with gaps");
        begin
            int beats = 0;
            int i = 0;
            while (beats < N) begin
                bit v = (i % 3) != 2;
                applyStimulus(0, v, 0);
                if (v) beats++;
                i++;
            end
        end

        $display("[TB] test 5: mid-frame flush");
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 1);
        for (int i = 0; i < 21; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        checkOutput("flush_entered", 32'(m_mode), 32'd2);
        drainToIdle(100);

        $display("[TB] test 6: reset during drain");
        for (int i = 0; i < N; i++) applyStimulus(0, 1, i == N - 1);
        repeat (19) applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0);
        for (int i = 0; i < N; i++) applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        drainToIdle(100);

        $display("[TB] test 7: random traffic");
        for (int i = 0; i < 1500; i++) begin
            bit r = ($urandom_range(0, 399) == 0);
            bit v = ($urandom_range(0, 9) < 7);
            bit f = ($urandom_range(0, 49) == 0);
            applyStimulus(r, v, f);
        end
        if (m_mode == 1) applyStimulus(0, 0, 1);
        for (int i = 0; i < N && m_mode == 1; i++) applyStimulus(0, 1, 0);
        drainToIdle(200);
        repeat (2) applyStimulus(0, 0, 0);
        checkOutput("out_queue_empty", 32'(out_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
